// File: rtl/msrv32_alu_arbiter.sv
// Round-robin sharing of the single msrv32 ALU between two requesters, each with
// a valid/ready request channel and a one-entry registered response buffer.
module msrv32_alu_arbiter #(
    parameter  int unsigned TAG_W  = 4,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned OPC_W  = 4
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_n_in,

    input  logic              req0_valid_in,
    output logic              req0_ready_out,
    input  logic [DATA_W-1:0] req0_op_1_in,
    input  logic [DATA_W-1:0] req0_op_2_in,
    input  logic [OPC_W-1:0]  req0_opcode_in,
    input  logic [TAG_W-1:0]  req0_tag_in,

    input  logic              req1_valid_in,
    output logic              req1_ready_out,
    input  logic [DATA_W-1:0] req1_op_1_in,
    input  logic [DATA_W-1:0] req1_op_2_in,
    input  logic [OPC_W-1:0]  req1_opcode_in,
    input  logic [TAG_W-1:0]  req1_tag_in,

    output logic              rsp0_valid_out,
    input  logic              rsp0_ready_in,
    output logic [DATA_W-1:0] rsp0_result_out,
    output logic [TAG_W-1:0]  rsp0_tag_out,
    output logic              rsp0_illegal_out,

    output logic              rsp1_valid_out,
    input  logic              rsp1_ready_in,
    output logic [DATA_W-1:0] rsp1_result_out,
    output logic [TAG_W-1:0]  rsp1_tag_out,
    output logic              rsp1_illegal_out,

    output logic [DATA_W-1:0] alu_op_1_out,
    output logic [DATA_W-1:0] alu_op_2_out,
    output logic [OPC_W-1:0]  alu_opcode_out,
    input  logic [DATA_W-1:0] alu_result_in
);

    // Encodings the ALU actually implements; anything else returns 0 and is flagged.
    function automatic logic opcode_legal(input logic [OPC_W-1:0] opc);
        case (opc)
            4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
            4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    logic              r_last_grant;
    logic              r_rsp0_valid;
    logic [DATA_W-1:0] r_rsp0_result;
    logic [TAG_W-1:0]  r_rsp0_tag;
    logic              r_rsp0_illegal;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp1_result;
    logic [TAG_W-1:0]  r_rsp1_tag;
    logic              r_rsp1_illegal;

    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;

    // A buffer being drained this cycle can accept a new result at the same edge.
    assign w_elig0 = req0_valid_in & (~r_rsp0_valid | rsp0_ready_in);
    assign w_elig1 = req1_valid_in & (~r_rsp1_valid | rsp1_ready_in);

    // On contention the requester that did not win last time gets the ALU.
    assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
    assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

    assign req0_ready_out = w_grant0;
    assign req1_ready_out = w_grant1;

    always_comb begin
        alu_op_1_out   = '0;
        alu_op_2_out   = '0;
        alu_opcode_out = '0;
        if (w_grant0) begin
            alu_op_1_out   = req0_op_1_in;
            alu_op_2_out   = req0_op_2_in;
            alu_opcode_out = req0_opcode_in;
        end else if (w_grant1) begin
            alu_op_1_out   = req1_op_1_in;
            alu_op_2_out   = req1_op_2_in;
            alu_opcode_out = req1_opcode_in;
        end
    end

    // Reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            r_rsp0_valid   <= 1'b0;
            r_rsp0_result  <= '0;
            r_rsp0_tag     <= '0;
            r_rsp0_illegal <= 1'b0;
        end else if (w_grant0) begin
            r_rsp0_valid   <= 1'b1;
            r_rsp0_result  <= alu_result_in;
            r_rsp0_tag     <= req0_tag_in;
            r_rsp0_illegal <= ~opcode_legal(req0_opcode_in);
        end else if (rsp0_ready_in) begin
            r_rsp0_valid   <= 1'b0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            r_rsp1_valid   <= 1'b0;
            r_rsp1_result  <= '0;
            r_rsp1_tag     <= '0;
            r_rsp1_illegal <= 1'b0;
        end else if (w_grant1) begin
            r_rsp1_valid   <= 1'b1;
            r_rsp1_result  <= alu_result_in;
            r_rsp1_tag     <= req1_tag_in;
            r_rsp1_illegal <= ~opcode_legal(req1_opcode_in);
        end else if (rsp1_ready_in) begin
            r_rsp1_valid   <= 1'b0;
        end
    end

    assign rsp0_valid_out   = r_rsp0_valid;
    assign rsp0_result_out  = r_rsp0_result;
    assign rsp0_tag_out     = r_rsp0_tag;
    assign rsp0_illegal_out = r_rsp0_illegal;
    assign rsp1_valid_out   = r_rsp1_valid;
    assign rsp1_result_out  = r_rsp1_result;
    assign rsp1_tag_out     = r_rsp1_tag;
    assign rsp1_illegal_out = r_rsp1_illegal;

endmodule
